// File: rtl/param_lock_pkg.sv
// Shared encoding helpers and the default secret for the param_lock combination lock.
// Latency: none (constants and a pure slicing function only).
// Backpressure: not applicable.
package param_lock_pkg;

    // UNLOCKED and LOCKOUT sit directly above the last stage index.
    localparam int ST_UNLOCKED_OFS = 0;
    localparam int ST_LOCKOUT_OFS  = 1;

    localparam logic [31:0] DEFAULT_CODES = 32'hA53CE17F;

    localparam int MAX_CODES_W  = 256;
    localparam int STAGE_CODE_W = 64;

    function automatic logic [STAGE_CODE_W-1:0] stage_code(
        input logic [MAX_CODES_W-1:0] codes,
        input int                     idx,
        input int                     width
    );
        logic [STAGE_CODE_W-1:0] mask;
        mask = (width >= STAGE_CODE_W) ? '1
             : ((STAGE_CODE_W'(1) << width) - STAGE_CODE_W'(1));
        return STAGE_CODE_W'(codes >> (idx * width)) & mask;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter that times the lockout window; zero flags an expired count.
// Latency: a load or decrement is visible one edge later; zero is combinational on the count.
// Backpressure: none; load takes priority over enable and the count sticks at zero.
module lock_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/param_lock.sv
// Parametrised multi-stage combination lock with fail counting, timed lockout and relock.
// Latency: every decision lands on the edge that samples it; all outputs are registered.
// Backpressure: none; codes are only looked at when code_valid is high (PARAM_LOCK_UNLOCK_ASSERT_EN adds an unlock trap).
module param_lock
    import param_lock_pkg::*;
#(
    parameter int CODE_WIDTH     = 8,
    parameter int NUM_STAGES     = 4,
    parameter logic [NUM_STAGES*CODE_WIDTH-1:0] CODES = DEFAULT_CODES,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 16,
    localparam int STATE_W = $clog2(NUM_STAGES + 2),
    localparam int FW      = (MAX_FAILS == 0) ? 1 : $clog2(MAX_FAILS + 1),
    localparam int TW      = (LOCKOUT_CYCLES <= 1) ? 1 : $clog2(LOCKOUT_CYCLES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CODE_WIDTH-1:0] code,
    input  logic                  code_valid,
    input  logic                  relock,
    output logic [STATE_W-1:0]    state,
    output logic                  unlocked,
    output logic                  locked_out,
    output logic [FW-1:0]         fail_count
);

    localparam logic [STATE_W-1:0]     S_FIRST    = '0;
    localparam logic [STATE_W-1:0]     S_LAST     = STATE_W'(NUM_STAGES - 1);
    localparam logic [STATE_W-1:0]     S_UNLOCKED = STATE_W'(NUM_STAGES + ST_UNLOCKED_OFS);
    localparam logic [STATE_W-1:0]     S_LOCKOUT  = STATE_W'(NUM_STAGES + ST_LOCKOUT_OFS);
    localparam logic [MAX_CODES_W-1:0] CODES_EXT  = MAX_CODES_W'(CODES);
    localparam logic [FW-1:0]          FAIL_MAX   = FW'(MAX_FAILS);
    localparam logic [TW-1:0]          TMR_LOAD   = TW'(LOCKOUT_CYCLES - 1);

    logic [STATE_W-1:0] next_state;
    logic [FW-1:0]      next_fail;
    logic [FW-1:0]      fail_inc;
    logic               in_stage;
    logic               code_hit;
    logic               mismatch;
    logic               trip;
    logic               tmr_load;
    logic               tmr_en;
    logic               tmr_zero;

    assign in_stage = (state < S_UNLOCKED);
    assign code_hit = (STAGE_CODE_W'(code) == stage_code(CODES_EXT, 32'(state), CODE_WIDTH));
    assign mismatch = in_stage && code_valid && !code_hit;
    assign fail_inc = (fail_count == FAIL_MAX) ? fail_count : fail_count + FW'(1);
    // A zero MAX_FAILS never trips, so the counter saturates at zero instead.
    assign trip     = (MAX_FAILS != 0) && (fail_inc == FAIL_MAX);

    lock_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (TMR_LOAD),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_FIRST;
            fail_count <= '0;
            unlocked   <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            state      <= next_state;
            fail_count <= next_fail;
            unlocked   <= (next_state == S_UNLOCKED);
            locked_out <= (next_state == S_LOCKOUT);
        end
    end

    always_comb begin
        next_state = state;
        if (in_stage) begin
            if (code_valid) begin
                if (!code_hit) begin
                    next_state = trip ? S_LOCKOUT : S_FIRST;
                end else if (state == S_LAST) begin
                    next_state = S_UNLOCKED;
                end else begin
                    next_state = state + STATE_W'(1);
                end
            end
        end else if (state == S_UNLOCKED) begin
            if (relock) begin
                next_state = S_FIRST;
            end
        end else if (state == S_LOCKOUT) begin
            if (tmr_zero) begin
                next_state = S_FIRST;
            end
        end else begin
            next_state = S_FIRST;
        end
    end

    always_comb begin
        next_fail = fail_count;
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        if (mismatch) begin
            next_fail = fail_inc;
            tmr_load  = trip;
        end else if (in_stage && code_valid && (state == S_LAST)) begin
            next_fail = '0;
        end
        if (state == S_LOCKOUT) begin
            tmr_en = 1'b1;
            if (tmr_zero) begin
                next_fail = '0;
            end
        end
    end

`ifdef PARAM_LOCK_UNLOCK_ASSERT_EN
    unlock_trap: assert property (@(posedge clk) disable iff (reset) !unlocked)
        else $error("SUCCESS: unlocked state has been reached.");
`endif

endmodule
